// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 control unit: FSM states, opcodes, select encodings
// and the packed control word produced by the output decoder.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_BR, S_JMP,
    S_LEA, S_ADDR, S_MEM, S_WB, S_STDAT, S_STWR
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_EAB = 2'b01;
  localparam logic [1:0] PC_BUS = 2'b10;

  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  typedef struct packed {
    logic       ena_marm, ena_pc, ena_mdr, ena_alu;
    logic       ld_mar, ld_mdr, ld_ir, ld_pc;
    logic       flag_we, reg_we, mem_we;
    logic       sel_mar, sel_mdr, sel_eab1;
    logic [1:0] sel_eab2;
    logic [1:0] sel_pc;
    logic [2:0] dr, sr1, sr2;
    logic [1:0] alu_ctrl;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [3:0] op);
    case (op)
      OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_LDR,
      OP_STR, OP_NOT, OP_JMP, OP_LEA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_outdec.sv
// Combinational control-word decoder: maps (state, IR, NZP, last wait cycle)
// onto every datapath control line.
module lc3_ctrl_outdec
  import lc3_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  input  logic        last_wait_i,
  output ctrl_t       cw_o
);

  logic [3:0] op;
  logic       unused_ir;
  assign op        = ir_i[15:12];
  assign unused_ir = ^ir_i[5:3];

  always_comb begin
    // NOTE: every field gets a default first, so no path through the case infers a latch.
    cw_o = '0;
    case (state_i)
      S_FETCH0: begin
        cw_o.ena_pc = 1'b1;
        cw_o.ld_mar = 1'b1;
      end
      S_FETCH1: begin
        cw_o.sel_mdr = 1'b1;
        cw_o.sel_pc  = PC_INC;
        cw_o.ld_mdr  = last_wait_i;
        cw_o.ld_pc   = last_wait_i;
      end
      S_FETCH2: begin
        cw_o.ena_mdr = 1'b1;
        cw_o.ld_ir   = 1'b1;
      end
      S_DECODE: cw_o.illegal_op = ~is_supported(op);
      S_EXEC: begin
        cw_o.sr1      = ir_i[8:6];
        cw_o.sr2      = ir_i[2:0];
        cw_o.dr       = ir_i[11:9];
        cw_o.alu_ctrl = (op == OP_AND) ? ALU_AND : (op == OP_NOT) ? ALU_NOT : ALU_ADD;
        cw_o.ena_alu  = 1'b1;
        cw_o.reg_we   = 1'b1;
        cw_o.flag_we  = 1'b1;
      end
      S_BR: begin
        if ((ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i)) begin
          cw_o.ld_pc    = 1'b1;
          cw_o.sel_pc   = PC_EAB;
          cw_o.sel_eab1 = 1'b0;
          cw_o.sel_eab2 = EAB2_OFF9;
        end
      end
      S_JMP: begin
        cw_o.sr1      = ir_i[8:6];
        cw_o.sel_eab1 = 1'b1;
        cw_o.sel_eab2 = EAB2_ZERO;
        cw_o.sel_pc   = PC_EAB;
        cw_o.ld_pc    = 1'b1;
      end
      S_LEA: begin
        cw_o.sel_eab2 = EAB2_OFF9;
        cw_o.ena_marm = 1'b1;
        cw_o.dr       = ir_i[11:9];
        cw_o.reg_we   = 1'b1;
        cw_o.flag_we  = 1'b1;
      end
      S_ADDR: begin
        cw_o.ena_marm = 1'b1;
        cw_o.ld_mar   = 1'b1;
        // Base+offset forms (LDR/STR) take the base register on EAB1.
        if (op == OP_LDR || op == OP_STR) begin
          cw_o.sel_eab1 = 1'b1;
          cw_o.sr1      = ir_i[8:6];
          cw_o.sel_eab2 = EAB2_OFF6;
        end else begin
          cw_o.sel_eab2 = EAB2_OFF9;
        end
      end
      S_MEM: begin
        cw_o.sel_mdr = 1'b1;
        cw_o.ld_mdr  = last_wait_i;
      end
      S_WB: begin
        cw_o.ena_mdr = 1'b1;
        cw_o.dr      = ir_i[11:9];
        cw_o.reg_we  = 1'b1;
        cw_o.flag_we = 1'b1;
      end
      S_STDAT: begin
        cw_o.sr1      = ir_i[11:9];
        cw_o.alu_ctrl = ALU_PASS;
        cw_o.ena_alu  = 1'b1;
        cw_o.ld_mdr   = 1'b1;
      end
      S_STWR:  cw_o.mem_we = last_wait_i;
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/lc3_controller.sv
// LC-3 control unit: holds the FSM state and memory wait counter; the output
// decoder turns them into datapath controls, forced to zero while in reset.
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        enaALU,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        ldIR,
  output logic        ldPC,
  output logic        flagWE,
  output logic        regWE,
  output logic        memWE,
  output logic        selMAR,
  output logic        selMDR,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic [1:0]  selPC,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [1:0]  ALUctrl,
  output logic        illegalOp
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_wait;
  ctrl_t      cw_dec, cw;

  assign last_wait = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: if (last_wait) state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          OP_ADD, OP_AND, OP_NOT:     state_d = S_EXEC;
          OP_BR:                      state_d = S_BR;
          OP_JMP:                     state_d = S_JMP;
          OP_LEA:                     state_d = S_LEA;
          OP_LD, OP_LDR, OP_ST, OP_STR: state_d = S_ADDR;
          default:                    state_d = S_FETCH0;
        endcase
      end
      S_ADDR:  state_d = (IR[15:12] == OP_LD || IR[15:12] == OP_LDR) ? S_MEM : S_STDAT;
      S_MEM:   if (last_wait) state_d = S_WB;
      S_STDAT: state_d = S_STWR;
      S_STWR:  if (last_wait) state_d = S_FETCH0;
      default: state_d = S_FETCH0;
    endcase

    // The counter reloads only on entry to an access state, so a stall
    // self-loop keeps counting down to the strobe cycle.
    if (state_d != state_q && (state_d == S_FETCH1 || state_d == S_MEM || state_d == S_STWR))
      cnt_d = WAIT_INIT;
    else if (!last_wait)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH0;
      cnt_q   <= 4'd0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  lc3_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .ir_i        (IR),
    .n_i         (N),
    .z_i         (Z),
    .p_i         (P),
    .last_wait_i (last_wait),
    .cw_o        (cw_dec)
  );

  assign cw = rst ? '0 : cw_dec;

  assign enaMARM   = cw.ena_marm;
  assign enaPC     = cw.ena_pc;
  assign enaMDR    = cw.ena_mdr;
  assign enaALU    = cw.ena_alu;
  assign ldMAR     = cw.ld_mar;
  assign ldMDR     = cw.ld_mdr;
  assign ldIR      = cw.ld_ir;
  assign ldPC      = cw.ld_pc;
  assign flagWE    = cw.flag_we;
  assign regWE     = cw.reg_we;
  assign memWE     = cw.mem_we;
  assign selMAR    = cw.sel_mar;
  assign selMDR    = cw.sel_mdr;
  assign selEAB1   = cw.sel_eab1;
  assign selEAB2   = cw.sel_eab2;
  assign selPC     = cw.sel_pc;
  assign DR        = cw.dr;
  assign SR1       = cw.sr1;
  assign SR2       = cw.sr2;
  assign ALUctrl   = cw.alu_ctrl;
  assign illegalOp = cw.illegal_op;

endmodule

// File: tb/tb_lc3_controller.sv
// Scoreboard bench for lc3_controller: per-cycle expected control words are
// queued per instruction and compared under a care mask as the FSM runs.
module tb_lc3_controller;

  typedef struct packed {
    logic [3:0] ena;   // {enaMARM, enaPC, enaMDR, enaALU}
    logic [3:0] ld;    // {ldMAR, ldMDR, ldIR, ldPC}
    logic [2:0] we;    // {flagWE, regWE, memWE}
    logic       sel_mar, sel_mdr, sel_eab1;
    logic [1:0] sel_eab2, sel_pc;
    logic [2:0] dr, sr1, sr2;
    logic [1:0] alu;
    logic       ill;
  } ov_t;

  typedef struct {
    ov_t   val;
    ov_t   mask;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir  = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  wire ov_t    o0, o3;
  bit          use3 = 1'b0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  lc3_controller #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .IR(ir), .N(n), .Z(z), .P(p),
    .enaMARM(o0.ena[3]), .enaPC(o0.ena[2]), .enaMDR(o0.ena[1]), .enaALU(o0.ena[0]),
    .ldMAR(o0.ld[3]), .ldMDR(o0.ld[2]), .ldIR(o0.ld[1]), .ldPC(o0.ld[0]),
    .flagWE(o0.we[2]), .regWE(o0.we[1]), .memWE(o0.we[0]),
    .selMAR(o0.sel_mar), .selMDR(o0.sel_mdr), .selEAB1(o0.sel_eab1),
    .selEAB2(o0.sel_eab2), .selPC(o0.sel_pc),
    .DR(o0.dr), .SR1(o0.sr1), .SR2(o0.sr2), .ALUctrl(o0.alu), .illegalOp(o0.ill)
  );

  lc3_controller #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .IR(ir), .N(n), .Z(z), .P(p),
    .enaMARM(o3.ena[3]), .enaPC(o3.ena[2]), .enaMDR(o3.ena[1]), .enaALU(o3.ena[0]),
    .ldMAR(o3.ld[3]), .ldMDR(o3.ld[2]), .ldIR(o3.ld[1]), .ldPC(o3.ld[0]),
    .flagWE(o3.we[2]), .regWE(o3.we[1]), .memWE(o3.we[0]),
    .selMAR(o3.sel_mar), .selMDR(o3.sel_mdr), .selEAB1(o3.sel_eab1),
    .selEAB2(o3.sel_eab2), .selPC(o3.sel_pc),
    .DR(o3.dr), .SR1(o3.sr1), .SR2(o3.sr2), .ALUctrl(o3.alu), .illegalOp(o3.ill)
  );

  function automatic ov_t cur();
    return use3 ? o3 : o0;
  endfunction

  // Strobes, enables and illegalOp are always checked; selects only where named.
  function automatic ov_t smask();
    ov_t m = '0;
    m.ena = '1; m.ld = '1; m.we = '1; m.ill = 1'b1;
    return m;
  endfunction

  task automatic push(input string tag, input ov_t v, input ov_t extra);
    exp_t e;
    e.val = v; e.mask = smask() | extra; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_f0();
    ov_t v = '0;
    v.ena = 4'b0100; v.ld = 4'b1000;
    push("FETCH0", v, '0);
  endtask

  task automatic push_fetch(input int w, input bit ill);
    ov_t v, m;
    push_f0();
    for (int i = 0; i <= w; i++) begin
      v = '0; m = '0;
      v.sel_mdr = 1'b1; m.sel_mdr = 1'b1;
      if (i == w) begin
        v.ld = 4'b0101; v.sel_pc = 2'b00; m.sel_pc = '1;
      end
      push("FETCH1", v, m);
    end
    v = '0; v.ena = 4'b0010; v.ld = 4'b0010;
    push("FETCH2", v, '0);
    v = '0; v.ill = ill;
    push("DECODE", v, '0);
  endtask

  // Releases reset, drains the scoreboard one entry per cycle and measures the
  // cycle index at which the next FETCH0 shows up.
  task automatic run(input string name, input int exp_len);
    ov_t  ob;
    exp_t e;
    int   meas = -1;
    @(posedge clk); #1 rst = 1'b0;
    for (int cyc = 0; cyc < 200 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      ob = cur();
      e  = sb.pop_front();
      checks++;
      if (((ob ^ e.val) & e.mask) !== '0) begin
        failures++;
        $display("FAIL %s/%s cyc=%0d: got %h expected %h (mask %h)", name, e.tag, cyc, ob, e.val, e.mask);
      end
      if (cyc > 0 && meas < 0 && ob.ena[2] && ob.ld[3]) meas = cyc;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s/timeout: %0d expectations left", name, sb.size());
      sb.delete();
    end
    checks++;
    if (meas !== exp_len) begin
      failures++;
      $display("FAIL %s/length: got %0d cycles expected %0d", name, meas, exp_len);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    ov_t v = '0;
    v.ena = 4'b0100; v.ld = 4'b1000;
    @(negedge clk);
    checks += 2;
    if (o0 !== '0) begin failures++; $display("FAIL reset_hold0: got %h expected 0", o0); end
    if (o3 !== '0) begin failures++; $display("FAIL reset_hold3: got %h expected 0", o3); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (((o3 ^ v) & smask()) !== '0) begin failures++; $display("FAIL reset_first_f0: got %h expected %h", o3, v); end
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks += 2;
    if (o3 !== '0) begin failures++; $display("FAIL reset_mid_fetch1: got %h expected 0", o3); end
    if (o0 !== '0) begin failures++; $display("FAIL reset_mid_dut0: got %h expected 0", o0); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (((o3 ^ v) & smask()) !== '0) begin failures++; $display("FAIL reset_restart_f0: got %h expected %h", o3, v); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_alu();
    ov_t v, m;
    use3 = 1'b0;
    ir = 16'h1283;
    push_fetch(0, 1'b0);
    v = '0; m = '0;
    v.ena = 4'b0001; v.we = 3'b110; v.dr = 3'd1; v.sr1 = 3'd2; v.sr2 = 3'd3; v.alu = 2'b00;
    m.dr = '1; m.sr1 = '1; m.sr2 = '1; m.alu = '1;
    push("EXEC", v, m);
    push_f0();
    run("add", 5);
    ir = 16'h967F;
    push_fetch(0, 1'b0);
    v = '0; m = '0;
    v.ena = 4'b0001; v.we = 3'b110; v.dr = 3'd3; v.sr1 = 3'd1; v.alu = 2'b10;
    m.dr = '1; m.sr1 = '1; m.alu = '1;
    push("EXEC", v, m);
    push_f0();
    run("not", 5);
  endtask

  task automatic test_branch();
    ov_t v, m;
    use3 = 1'b0;
    ir = 16'h0A05; {n, z, p} = 3'b010;
    push_fetch(0, 1'b0);
    push("BR_NOT_TAKEN", '0, '0);
    push_f0();
    run("br_z", 5);
    {n, z, p} = 3'b100;
    push_fetch(0, 1'b0);
    v = '0; m = '0;
    v.ld = 4'b0001; v.sel_pc = 2'b01; v.sel_eab1 = 1'b0; v.sel_eab2 = 2'b10;
    m.sel_pc = '1; m.sel_eab1 = 1'b1; m.sel_eab2 = '1;
    push("BR_TAKEN", v, m);
    push_f0();
    run("br_n", 5);
    ir = 16'h0005; {n, z, p} = 3'b111;
    push_fetch(0, 1'b0);
    push("BR_NZP000", '0, '0);
    push_f0();
    run("br_000", 5);
    {n, z, p} = 3'b000;
  endtask

  task automatic test_jmp_lea();
    ov_t v, m;
    use3 = 1'b0;
    ir = 16'hC080;
    push_fetch(0, 1'b0);
    v = '0; m = '0;
    v.ld = 4'b0001; v.sr1 = 3'd2; v.sel_eab1 = 1'b1; v.sel_eab2 = 2'b00; v.sel_pc = 2'b01;
    m.sr1 = '1; m.sel_eab1 = 1'b1; m.sel_eab2 = '1; m.sel_pc = '1;
    push("JMP", v, m);
    push_f0();
    run("jmp", 5);
    ir = 16'hE603;
    push_fetch(0, 1'b0);
    v = '0; m = '0;
    v.ena = 4'b1000; v.we = 3'b110; v.dr = 3'd3; v.sel_mar = 1'b0; v.sel_eab1 = 1'b0; v.sel_eab2 = 2'b10;
    m.dr = '1; m.sel_mar = 1'b1; m.sel_eab1 = 1'b1; m.sel_eab2 = '1;
    push("LEA", v, m);
    push_f0();
    run("lea", 5);
  endtask

  task automatic push_addr(input bit base_reg, input logic [2:0] base);
    ov_t v = '0, m = '0;
    v.ena = 4'b1000; v.ld = 4'b1000; v.sel_mar = 1'b0;
    m.sel_mar = 1'b1; m.sel_eab1 = 1'b1; m.sel_eab2 = '1;
    if (base_reg) begin
      v.sel_eab1 = 1'b1; v.sr1 = base; v.sel_eab2 = 2'b01; m.sr1 = '1;
    end else begin
      v.sel_eab1 = 1'b0; v.sel_eab2 = 2'b10;
    end
    push("ADDR", v, m);
  endtask

  task automatic test_load();
    ov_t v, m;
    use3 = 1'b1;
    ir = 16'h6442;
    push_fetch(3, 1'b0);
    push_addr(1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      v = '0; m = '0; v.sel_mdr = 1'b1; m.sel_mdr = 1'b1;
      if (i == 3) v.ld = 4'b0100;
      push("MEM", v, m);
    end
    v = '0; m = '0;
    v.ena = 4'b0010; v.we = 3'b110; v.dr = 3'd2; m.dr = '1;
    push("WB", v, m);
    push_f0();
    run("ldr_w3", 13);
    use3 = 1'b0;
    ir = 16'h2205;
    push_fetch(0, 1'b0);
    push_addr(1'b0, 3'd0);
    v = '0; m = '0; v.sel_mdr = 1'b1; v.ld = 4'b0100; m.sel_mdr = 1'b1;
    push("MEM", v, m);
    v = '0; m = '0;
    v.ena = 4'b0010; v.we = 3'b110; v.dr = 3'd1; m.dr = '1;
    push("WB", v, m);
    push_f0();
    run("ld_w0", 7);
  endtask

  task automatic test_store();
    ov_t v, m;
    use3 = 1'b1;
    ir = 16'h7642;
    push_fetch(3, 1'b0);
    push_addr(1'b1, 3'd1);
    v = '0; m = '0;
    v.ena = 4'b0001; v.ld = 4'b0100; v.sr1 = 3'd3; v.alu = 2'b11; v.sel_mdr = 1'b0;
    m.sr1 = '1; m.alu = '1; m.sel_mdr = 1'b1;
    push("STDAT", v, m);
    for (int i = 0; i < 4; i++) begin
      v = '0;
      if (i == 3) v.we = 3'b001;
      push("STWR", v, '0);
    end
    push_f0();
    run("str_w3", 13);
  endtask

  task automatic test_illegal();
    use3 = 1'b0;
    ir = 16'hF025;
    push_fetch(0, 1'b1);
    push_f0();
    run("trap_w0", 4);
    use3 = 1'b1;
    ir = 16'hD000;
    push_fetch(3, 1'b1);
    push_f0();
    run("reserved_w3", 7);
  endtask

  task automatic test_onehot_random();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks += 2;
      if ($countones(o0.ena) > 1) begin failures++; $display("FAIL onehot0 cyc=%0d: got %b expected at most one", i, o0.ena); end
      if ($countones(o3.ena) > 1) begin failures++; $display("FAIL onehot3 cyc=%0d: got %b expected at most one", i, o3.ena); end
      @(posedge clk); #1;
      ir = 16'($urandom);
      {n, z, p} = 3'($urandom_range(0, 7));
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jmp_lea();
    test_load();
    test_store();
    test_illegal();
    test_onehot_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
